// File: rtl/apb_master_bridge.sv
// ----------------------------------------------------------------------------
// apb_master_bridge
//
// Single-outstanding APB requester. A command accepted on the valid/ready port
// becomes one APB SETUP + ACCESS transfer. Completion is reported as a
// one-cycle rsp_valid pulse that carries read data or a timeout error.
//
// Ports
//   pclk, prst_n        clock and async active-low reset
//   req_valid/ready     command handshake (ready only while idle)
//   req_write           1 = write, 0 = read
//   req_addr/wdata      command address and write data
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata           read data (0 for writes and errors), held
//   rsp_err             1 = ACCESS timed out waiting for pready, held
//   psel/pen/pwrite     APB control
//   paddr/pwdata        APB address and write data (registered)
//   prdata/pready       APB slave response
// ----------------------------------------------------------------------------
module apb_master_bridge #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              pclk,
   input  logic              prst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              psel,
   output logic              pen,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready
);

   // Counter only has to reach TIMEOUT-1, so it never wraps.
   localparam int CNT_W = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam bit TO_EN = (TIMEOUT != 0);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_e;

   state_e              r_state;
   state_e              w_next_state;
   logic [CNT_W-1:0]    r_wait_cnt;
   logic                r_pwrite;
   logic [ADDR_W-1:0]   r_paddr;
   logic [DATA_W-1:0]   r_pwdata;
   logic                r_rsp_valid;
   logic [DATA_W-1:0]   r_rsp_rdata;
   logic                r_rsp_err;

   logic                w_accept;
   logic                w_done_ok;
   logic                w_done_to;
   logic                w_timeout_hit;

   assign w_timeout_hit = TO_EN && (r_wait_cnt == CNT_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, regardless of process ordering.
   always_ff @(posedge pclk or negedge prst_n) begin
      if (!prst_n) r_state <= ST_IDLE;
      else         r_state <= w_next_state;
   end

   // NOTE: every signal written here gets a default first; a missing branch
   // would otherwise infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_done_ok    = 1'b0;
      w_done_to    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_accept     = 1'b1;
               w_next_state = ST_SETUP;
            end
         end
         ST_SETUP: w_next_state = ST_ACCESS;
         ST_ACCESS: begin
            // pready has priority over a timeout on the same edge.
            if (pready) begin
               w_done_ok    = 1'b1;
               w_next_state = ST_IDLE;
            end else if (w_timeout_hit) begin
               w_done_to    = 1'b1;
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge prst_n) begin
      if (!prst_n) begin
         r_wait_cnt  <= '0;
         r_pwrite    <= 1'b0;
         r_paddr     <= '0;
         r_pwdata    <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_rsp_valid <= w_done_ok | w_done_to;

         if (w_accept) begin
            r_pwrite   <= req_write;
            r_paddr    <= req_addr;
            r_pwdata   <= req_wdata;
            r_wait_cnt <= '0;
         end else if (r_state == ST_ACCESS && !pready && !w_done_to) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end

         // Response fields only change on a completion and hold otherwise.
         if (w_done_ok) begin
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= r_pwrite ? '0 : prdata;
         end else if (w_done_to) begin
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
         end
      end
   end

   // Bus controls decode straight from state so reset drops them at once.
   assign req_ready = (r_state == ST_IDLE);
   assign psel      = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
   assign pen       = (r_state == ST_ACCESS);
   assign pwrite    = r_pwrite;
   assign paddr     = r_paddr;
   assign pwdata    = r_pwdata;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master_bridge.sv
// ----------------------------------------------------------------------------
// tb_apb_master_bridge
//
// Drives commands into apb_master_bridge (TIMEOUT=4) against a simple APB
// slave memory whose wait-state count is set per transfer. Expected latency,
// error flag and read data come from a transaction-level reference: a word
// array updated only by writes that complete before the timeout.
// ----------------------------------------------------------------------------
module tb_apb_master_bridge;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic          pclk = 1'b0;
   logic          prst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_write = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          psel, pen, pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic [DW-1:0] prdata;
   logic          pready;

   apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .pclk(pclk), .prst_n(prst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .psel(psel), .pen(pen), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready)
   );

   always #5 pclk = ~pclk;

   int cyc = 0;
   always @(posedge pclk) cyc <= cyc + 1;

   // APB slave: memory of 256 words, pready after slv_waits ACCESS cycles.
   int          slv_waits = 0;
   int          slv_cnt;
   logic [31:0] slv_mem [0:255];

   assign pready = psel && pen && (slv_cnt >= slv_waits);
   assign prdata = slv_mem[paddr[9:2]];

   always @(posedge pclk or negedge prst_n) begin
      if (!prst_n) slv_cnt <= 0;
      else if (psel && pen) begin
         if (pready) begin
            slv_cnt <= 0;
            if (pwrite) slv_mem[paddr[9:2]] <= pwdata;
         end else begin
            slv_cnt <= slv_cnt + 1;
         end
      end else slv_cnt <= 0;
   end

   // Reference model state.
   logic [31:0] ref_mem [0:255];

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // One command. Called #1 after a rising edge; returns #1 after the edge
   // on which rsp_valid was observed (or the bound expired).
   task automatic do_txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input int waits, output int acc_cyc);
      int n;
      int lat;
      int pen_cyc;
      int exp_lat;
      logic exp_err;
      logic [31:0] exp_rd;
      n = 0;
      while (!req_ready && n < 30) begin
         @(posedge pclk); #1; n++;
      end
      check("req_ready_before_cmd", req_ready, 1);
      slv_waits = waits;
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
      @(posedge pclk); #1;
      acc_cyc   = cyc;
      req_valid = 1'b0;
      req_wdata = $urandom; // prove pwdata is held, not passed through
      req_addr  = $urandom;

      // Transaction-level expectation.
      if (waits < TO) begin
         exp_lat = 2 + waits;
         exp_err = 1'b0;
         exp_rd  = wr ? 32'h0 : ref_mem[a[9:2]];
         if (wr) ref_mem[a[9:2]] = d;
      end else begin
         exp_lat = TO + 1;
         exp_err = 1'b1;
         exp_rd  = 32'h0;
      end

      lat = 0; pen_cyc = 0;
      while (!rsp_valid && lat < 20) begin
         check("psel_in_xfer", psel, 1);
         check("paddr_stable", paddr, a);
         check("pwrite_stable", pwrite, wr);
         check("pwdata_stable", pwdata, d);
         if (pen) pen_cyc++;
         @(posedge pclk); #1; lat++;
      end
      check("rsp_latency", lat, exp_lat);
      check("rsp_err", rsp_err, exp_err);
      check("rsp_rdata", rsp_rdata, exp_rd);
      check("pen_cycles", pen_cyc, exp_lat - 1);
      check("psel_low_in_rsp", psel, 0);
      check("req_ready_in_rsp", req_ready, 1);
      check("paddr_hold", paddr, a);
   endtask

   task automatic idle_cycle();
      @(posedge pclk); #1;
      check("idle_rsp_valid", rsp_valid, 0);
      check("idle_psel", psel, 0);
      check("idle_pen", pen, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int acc0, acc1, acc2;
      int a;
      logic wr;
      logic [31:0] d;
      for (int i = 0; i < 256; i++) begin
         slv_mem[i] = '0;
         ref_mem[i] = '0;
      end

      // Reset state.
      #1;
      check("rst_psel", psel, 0);
      check("rst_pen", pen, 0);
      check("rst_pwrite", pwrite, 0);
      check("rst_paddr", paddr, 0);
      check("rst_pwdata", pwdata, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_req_ready", req_ready, 1);
      repeat (2) @(negedge pclk);
      prst_n = 1'b1;
      @(posedge pclk); #1;

      // Zero-wait write then read at the same address.
      do_txn(1'b1, 32'h4, 32'hDEADBEEF, 0, acc0);
      idle_cycle();
      do_txn(1'b0, 32'h4, 32'h0, 0, acc0);
      check("read_back_deadbeef", rsp_rdata, 32'hDEADBEEF);
      idle_cycle();

      // Three slave wait states.
      do_txn(1'b1, 32'h80, 32'hA5A5_0001, 3, acc0);
      idle_cycle();

      // Stuck pready: timeout, then a normal command.
      do_txn(1'b1, 32'h84, 32'h1234_5678, 100, acc0);
      idle_cycle();
      do_txn(1'b0, 32'h84, 32'h0, 0, acc0);
      idle_cycle();

      // Boundary: pready on the 4th ACCESS cycle wins; one more is a timeout.
      do_txn(1'b0, 32'h80, 32'h0, TO - 1, acc0);
      do_txn(1'b1, 32'h88, 32'hCAFE_F00D, TO, acc0);
      idle_cycle();

      // Back-to-back: command presented again in each response cycle.
      do_txn(1'b1, 32'h10, 32'h1111_1111, 0, acc0);
      do_txn(1'b1, 32'h14, 32'h2222_2222, 0, acc1);
      do_txn(1'b0, 32'h10, 32'h0, 0, acc2);
      check("b2b_spacing_1", acc1 - acc0, 3);
      check("b2b_spacing_2", acc2 - acc1, 3);
      idle_cycle();

      // Randomized traffic on a small address window so reads hit writes.
      for (int k = 0; k < 40; k++) begin
         a  = $urandom_range(0, 15) * 4;
         wr = 1'($urandom_range(0, 1));
         d  = $urandom;
         do_txn(wr, 32'(a), d, $urandom_range(0, 6), acc0);
         repeat ($urandom_range(0, 2)) idle_cycle();
      end

      // Reset in the middle of ACCESS.
      slv_waits = 100;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40; req_wdata = '0;
      @(posedge pclk); #1;
      req_valid = 1'b0;
      @(posedge pclk); #1;
      check("pre_rst_pen", pen, 1);
      @(posedge pclk); #2;
      prst_n = 1'b0;
      #1;
      check("async_rst_psel", psel, 0);
      check("async_rst_pen", pen, 0);
      check("async_rst_rsp_valid", rsp_valid, 0);
      check("async_rst_req_ready", req_ready, 1);
      @(negedge pclk);
      prst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         idle_cycle();
         check("post_rst_ready", req_ready, 1);
      end
      do_txn(1'b0, 32'h4, 32'h0, 1, acc0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
